// File: rtl/strip_placer_if.sv
// Request, response and strip-RAM signals of strip_placer, bundled as one port.
// The master side is the placement controller; the slave side is the request source plus RAM.
interface strip_placer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_width;
    logic [DATA_WIDTH-1:0] req_height;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_fail;
    logic [ADDR_WIDTH-1:0] resp_strip;
    logic [DATA_WIDTH-1:0] resp_base;

    logic                  ram_read_en;
    logic                  ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_addr_read1;
    logic [ADDR_WIDTH-1:0] ram_addr_read2;
    logic [ADDR_WIDTH-1:0] ram_addr_read3;
    logic [ADDR_WIDTH-1:0] ram_addr_write;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out1;
    logic [DATA_WIDTH-1:0] ram_data_out2;
    logic [DATA_WIDTH-1:0] ram_data_out3;

    modport master (
        input  req_valid, req_width, req_height, resp_ready,
        input  ram_data_out1, ram_data_out2, ram_data_out3,
        output req_ready, resp_valid, resp_fail, resp_strip, resp_base,
        output ram_read_en, ram_write_en, ram_addr_read1, ram_addr_read2, ram_addr_read3,
        output ram_addr_write, ram_data_in
    );

    modport slave (
        output req_valid, req_width, req_height, resp_ready,
        output ram_data_out1, ram_data_out2, ram_data_out3,
        input  req_ready, resp_valid, resp_fail, resp_strip, resp_base,
        input  ram_read_en, ram_write_en, ram_addr_read1, ram_addr_read2, ram_addr_read3,
        input  ram_addr_write, ram_data_in
    );
endinterface

// File: rtl/strip_placer.sv
// Places one program of W adjacent strips and height H at the window with the lowest resulting
// top, scanning the strip-height RAM one window per cycle and writing the new top back.
module strip_placer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_STRIPS   = 13,
    parameter int HEIGHT_LIMIT = 128
) (
    input logic            clk,
    input logic            rst,
    strip_placer_if.master bus
);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, WRITE, RESP} state_e;

    localparam logic [ADDR_WIDTH-1:0] STRIPS_P1 = ADDR_WIDTH'(NUM_STRIPS + 1);
    localparam logic [DATA_WIDTH:0]   LIMIT     = (DATA_WIDTH + 1)'(HEIGHT_LIMIT);

    state_e                state_q, state_d;
    logic                  armed_q;
    logic [1:0]            w_q, w_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [ADDR_WIDTH-1:0] s_q, s_d;
    logic [1:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] best_s_q, best_s_d;
    logic [DATA_WIDTH:0]   best_top_q, best_top_d;
    logic [DATA_WIDTH-1:0] best_base_q, best_base_d;
    logic                  resp_fail_q, resp_fail_d;
    logic [ADDR_WIDTH-1:0] resp_strip_q, resp_strip_d;
    logic [DATA_WIDTH-1:0] resp_base_q, resp_base_d;

    logic [ADDR_WIDTH-1:0] last_s;
    logic [DATA_WIDTH-1:0] win_max;
    logic [DATA_WIDTH:0]   win_top;
    logic                  eval_en;
    logic                  take;

    // Read data arriving this cycle belongs to window s-1; DRAIN sees the final window.
    assign last_s  = STRIPS_P1 - ADDR_WIDTH'(w_q);
    assign eval_en = ((state_q == SCAN) && (s_q != ADDR_WIDTH'(1))) || (state_q == DRAIN);
    assign win_top = {1'b0, win_max} + {1'b0, h_q};
    assign take    = eval_en && (win_top < best_top_q);

    always_comb begin
        win_max = bus.ram_data_out1;
        if (bus.ram_data_out2 > win_max) win_max = bus.ram_data_out2;
        if (bus.ram_data_out3 > win_max) win_max = bus.ram_data_out3;
    end

    // NOTE: reset is sampled on the clock edge only; all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            w_q          <= '0;
            h_q          <= '0;
            s_q          <= '0;
            k_q          <= '0;
            best_s_q     <= '0;
            best_top_q   <= '1;
            best_base_q  <= '0;
            resp_fail_q  <= 1'b0;
            resp_strip_q <= '0;
            resp_base_q  <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= 1'b1;
            w_q          <= w_d;
            h_q          <= h_d;
            s_q          <= s_d;
            k_q          <= k_d;
            best_s_q     <= best_s_d;
            best_top_q   <= best_top_d;
            best_base_q  <= best_base_d;
            resp_fail_q  <= resp_fail_d;
            resp_strip_q <= resp_strip_d;
            resp_base_q  <= resp_base_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        s_d          = s_q;
        k_d          = k_q;
        best_s_d     = best_s_q;
        best_top_d   = best_top_q;
        best_base_d  = best_base_q;
        resp_fail_d  = resp_fail_q;
        resp_strip_d = resp_strip_q;
        resp_base_d  = resp_base_q;

        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_fail      = resp_fail_q;
        bus.resp_strip     = resp_strip_q;
        bus.resp_base      = resp_base_q;
        bus.ram_read_en    = 1'b0;
        bus.ram_write_en   = 1'b0;
        bus.ram_addr_read1 = '0;
        bus.ram_addr_read2 = '0;
        bus.ram_addr_read3 = '0;
        bus.ram_addr_write = '0;
        bus.ram_data_in    = '0;

        if (take) begin
            best_s_d    = s_q - ADDR_WIDTH'(1);
            best_top_d  = win_top;
            best_base_d = win_max;
        end

        unique case (state_q)
            IDLE: begin
                bus.req_ready = armed_q;
                if (armed_q && bus.req_valid) begin
                    w_d         = bus.req_width;
                    h_d         = bus.req_height;
                    s_d         = ADDR_WIDTH'(1);
                    k_d         = '0;
                    best_s_d    = '0;
                    best_top_d  = '1;
                    best_base_d = '0;
                    if (bus.req_width == 2'd0) begin
                        resp_fail_d  = 1'b1;
                        resp_strip_d = '0;
                        resp_base_d  = '0;
                        state_d      = RESP;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Unused read ports repeat a covered strip so they never raise the maximum.
                bus.ram_read_en    = 1'b1;
                bus.ram_addr_read1 = s_q;
                bus.ram_addr_read2 = s_q + ADDR_WIDTH'(w_q >= 2'd2);
                bus.ram_addr_read3 = s_q + ((w_q == 2'd3) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(0));
                s_d                = s_q + ADDR_WIDTH'(1);
                if (s_q == last_s) state_d = DRAIN;
            end
            DRAIN: begin
                if (best_top_d > LIMIT) begin
                    resp_fail_d  = 1'b1;
                    resp_strip_d = '0;
                    resp_base_d  = '0;
                    state_d      = RESP;
                end else begin
                    resp_fail_d  = 1'b0;
                    resp_strip_d = best_s_d;
                    resp_base_d  = best_base_d;
                    k_d          = '0;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                bus.ram_write_en   = 1'b1;
                bus.ram_addr_write = best_s_q + ADDR_WIDTH'(k_q);
                bus.ram_data_in    = best_top_q[DATA_WIDTH-1:0];
                k_d                = k_q + 2'd1;
                if (k_q == w_q - 2'd1) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_strip_placer.sv
// Self-checking bench for strip_placer: a behavioural strip RAM plus a window-search reference
// model, directed scenarios and randomized requests.
module tb_strip_placer;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int NS  = 13;
    localparam int LIM = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    strip_placer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    strip_placer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STRIPS(NS), .HEIGHT_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Strip RAM: registered reads, one write port, plus a preload port for the bench.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int unsigned   wr_pulses = 0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (bus.ram_write_en) begin
            mem[bus.ram_addr_write] <= bus.ram_data_in;
            wr_pulses <= wr_pulses + 1;
        end
        if (bus.ram_read_en) begin
            bus.ram_data_out1 <= mem[bus.ram_addr_read1];
            bus.ram_data_out2 <= mem[bus.ram_addr_read2];
            bus.ram_data_out3 <= mem[bus.ram_addr_read3];
        end
    end

    logic [DW-1:0] ref_mem [0:NS];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] all_outs();
        return {bus.req_ready, bus.resp_valid, bus.resp_fail, bus.resp_strip, bus.resp_base,
                bus.ram_read_en, bus.ram_write_en, bus.ram_addr_read1, bus.ram_addr_read2,
                bus.ram_addr_read3, bus.ram_addr_write, bus.ram_data_in};
    endfunction

    task automatic load_ram();
        for (int i = 0; i <= NS; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 0) ? '0 : ref_mem[i];
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic fill_ref(input int v);
        ref_mem[0] = '0;
        for (int i = 1; i <= NS; i++) ref_mem[i] = DW'(v);
    endtask

    // Exhaustive window search: lowest top wins, first (lowest strip) wins ties.
    task automatic ref_place(input int w, input int h, output bit fail, output int strip,
                             output int base, output int lat);
        int n, best_top, best_s, best_m, m;
        fail = 1'b0; strip = 0; base = 0;
        if (w == 0) begin
            fail = 1'b1;
            lat  = 1;
            return;
        end
        n = NS - w + 1;
        best_top = 1 << 30; best_s = 0; best_m = 0;
        for (int s = 1; s <= n; s++) begin
            m = 0;
            for (int j = 0; j < w; j++) if (int'(ref_mem[s+j]) > m) m = int'(ref_mem[s+j]);
            if (m + h < best_top) begin
                best_top = m + h; best_s = s; best_m = m;
            end
        end
        if (best_top > LIM) begin
            fail = 1'b1;
            lat  = n + 2;
        end else begin
            strip = best_s;
            base  = best_m;
            lat   = n + 2 + w;
            for (int j = 0; j < w; j++) ref_mem[best_s+j] = DW'(best_top);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 1; i <= NS; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s ram contents: %0d strips differ from model, want 0", tag, bad);
        end
    endtask

    task automatic do_txn(input int w, input int h, input string tag);
        bit          e_fail;
        int          e_strip, e_base, e_lat, lat, e_wr;
        int unsigned wr0;
        ref_place(w, h, e_fail, e_strip, e_base, e_lat);
        e_wr = e_fail ? 0 : w;
        wr0  = wr_pulses;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_width  = 2'(w);
        bus.req_height = DW'(h);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready before request: got %b want 1", tag, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++; $display("FAIL %s resp_valid timeout after %0d cycles", tag, lat);
            return;
        end
        checks++;
        if (lat != e_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
        end
        checks++;
        if (bus.resp_fail !== e_fail) begin
            errors++; $display("FAIL %s resp_fail: got %b want %b", tag, bus.resp_fail, e_fail);
        end
        checks++;
        if (bus.resp_strip !== AW'(e_strip)) begin
            errors++; $display("FAIL %s resp_strip: got %0d want %0d", tag, bus.resp_strip, e_strip);
        end
        checks++;
        if (bus.resp_base !== DW'(e_base)) begin
            errors++; $display("FAIL %s resp_base: got %0d want %0d", tag, bus.resp_base, e_base);
        end
        checks++;
        if (int'(wr_pulses - wr0) != e_wr) begin
            errors++; $display("FAIL %s write pulses: got %0d want %0d", tag, wr_pulses - wr0, e_wr);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake: valid=%b ready=%b want valid=0 ready=1",
                     tag, bus.resp_valid, bus.req_ready);
        end
        check_mem(tag);
    endtask

    task automatic test_reset();
        fill_ref(0);
        load_ram();
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset outputs: got %h want 0", all_outs());
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset release: ready=%b valid=%b want ready=1 valid=0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_plan_sequence();
        fill_ref(0);
        load_ram();
        do_txn(3, 10, "w3_h10");
        do_txn(1, 5, "w1_h5");
    endtask

    task automatic test_valley();
        fill_ref(20);
        ref_mem[7] = 8'd3;
        ref_mem[8] = 8'd3;
        load_ram();
        do_txn(2, 4, "valley");
    endtask

    task automatic test_tie();
        fill_ref(0);
        load_ram();
        do_txn(2, 1, "tie");
    endtask

    task automatic test_overflow();
        fill_ref(0);
        load_ram();
        do_txn(1, 129, "over_129");
        do_txn(1, 128, "at_limit");
        fill_ref(200);
        load_ram();
        do_txn(2, 255, "no_wrap");
    endtask

    task automatic test_illegal_width();
        do_txn(0, 50, "w0");
    endtask

    task automatic test_reset_mid_scan();
        int unsigned wr0;
        fill_ref(0);
        load_ram();
        wr0 = wr_pulses;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_width  = 2'd2;
        bus.req_height = 8'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ram_read_en !== 1'b1) begin
            errors++; $display("FAIL midscan read_en before reset: got %b want 1", bus.ram_read_en);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL midscan reset outputs: got %h want 0", all_outs());
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || wr_pulses != wr0) begin
            errors++;
            $display("FAIL midscan release: ready=%b valid=%b writes=%0d want 1 0 0",
                     bus.req_ready, bus.resp_valid, wr_pulses - wr0);
        end
        check_mem("midscan");
        do_txn(2, 7, "after_reset");
    endtask

    task automatic test_backpressure();
        bit                 e_fail;
        int                 e_strip, e_base, e_lat, lat;
        logic [AW+DW:0]     snap;
        ref_mem[0] = '0;
        for (int i = 1; i <= NS; i++) ref_mem[i] = DW'(i * 3);
        load_ram();
        ref_place(2, 9, e_fail, e_strip, e_base, e_lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_width  = 2'd2;
        bus.req_height = 8'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure resp_valid timeout");
            return;
        end
        checks++;
        if ({bus.resp_fail, bus.resp_strip, bus.resp_base} !== {e_fail, AW'(e_strip), DW'(e_base)}) begin
            errors++;
            $display("FAIL backpressure result: got fail=%b strip=%0d base=%0d want %b %0d %0d",
                     bus.resp_fail, bus.resp_strip, bus.resp_base, e_fail, e_strip, e_base);
        end
        snap = {bus.resp_fail, bus.resp_strip, bus.resp_base};
        bus.req_valid  = 1'b1;
        bus.req_width  = 2'd1;
        bus.req_height = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.ram_read_en !== 1'b0 ||
                {bus.resp_fail, bus.resp_strip, bus.resp_base} !== snap) begin
                errors++;
                $display("FAIL backpressure hold %0d: valid=%b ready=%b rd=%b resp=%h want 1 0 0 %h",
                         c, bus.resp_valid, bus.req_ready, bus.ram_read_en,
                         {bus.resp_fail, bus.resp_strip, bus.resp_base}, snap);
            end
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_read_en !== 1'b0) begin
            errors++;
            $display("FAIL backpressure handshake: valid=%b ready=%b rd=%b want 0 1 0",
                     bus.resp_valid, bus.req_ready, bus.ram_read_en);
        end
        check_mem("backpressure");
    endtask

    task automatic test_random();
        int w, h;
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0) begin
                ref_mem[0] = '0;
                for (int i = 1; i <= NS; i++) ref_mem[i] = DW'($urandom_range(0, 90));
                load_ram();
            end
            w = int'($urandom_range(0, 3));
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 255))
                                            : int'($urandom_range(0, 30));
            do_txn(w, h, "random");
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_width  = '0;
        bus.req_height = '0;
        bus.resp_ready = 1'b0;
        pre_en         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        rst            = 1'b0;
        test_reset();
        test_plan_sequence();
        test_valley();
        test_tie();
        test_overflow();
        test_illegal_width();
        test_reset_mid_scan();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
